// File: rtl/param_sequence_generator.sv
// -----------------------------------------------------------------------------
// param_sequence_generator
//
// One-hot control-step sequencer for the CPU decoder. It walks the steps
// 0 .. STEP_COUNT-1: the first FETCH_STEPS steps are fetch, the next step is
// decode and the remaining steps are execute. The last fetch step also serves
// as the PC-increment step.
//
// Beyond the plain ring counter it supports:
//   - early termination of an instruction (input_finish) during execute steps
//   - halt requests, which take effect only on an instruction boundary
//   - resume out of HALTED
//   - a wrapping count of completed instructions
//
// Handshake/timing: there is no valid/ready pair. Every registered update
// happens on a rising clock edge with input_clock_enable=1. The one exception
// is output_instr_done, which is high for exactly one cycle after the
// completing edge and drops on the next edge whatever the enable is. The
// phase strobes are decoded combinationally from the registered index and
// state.
//
// Ports:
//   clock               rising-edge system clock
//   input_reset_n       asynchronous active-low reset
//   input_clock_enable  advance enable; 0 holds index/state/pending/count
//   input_clear         synchronous restart to step 0 (also leaves HALTED)
//   input_finish        early end of instruction (execute steps only)
//   input_halt          halt request, taken at the next instruction boundary
//   input_resume        leave HALTED, restart at step 0
//   output_step         one-hot current step; all zero when halted
//   output_step_index   binary current step; 0 when halted
//   output_fetch        index <  FETCH_STEPS
//   output_decode       index == FETCH_STEPS
//   output_execute      index >  FETCH_STEPS
//   output_increment    index == FETCH_STEPS-1
//   output_halted       in HALTED (this is the FSM state)
//   output_instr_done   one-cycle pulse after an instruction completes
//   output_instr_count  completed instructions, wraps modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module param_sequence_generator #(
  parameter int STEP_COUNT  = 6,
  parameter int FETCH_STEPS = 2,
  parameter int COUNT_WIDTH = 8,
  localparam int STEP_W     = $clog2(STEP_COUNT)
) (
  input  logic                   clock,
  input  logic                   input_reset_n,
  input  logic                   input_clock_enable,
  input  logic                   input_clear,
  input  logic                   input_finish,
  input  logic                   input_halt,
  input  logic                   input_resume,
  output logic [STEP_COUNT-1:0]  output_step,
  output logic [STEP_W-1:0]      output_step_index,
  output logic                   output_fetch,
  output logic                   output_decode,
  output logic                   output_execute,
  output logic                   output_increment,
  output logic                   output_halted,
  output logic                   output_instr_done,
  output logic [COUNT_WIDTH-1:0] output_instr_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [STEP_W-1:0] LAST_IDX   = STEP_W'(STEP_COUNT - 1);
  localparam logic [STEP_W-1:0] DECODE_IDX = STEP_W'(FETCH_STEPS);
  localparam logic [STEP_W-1:0] INC_IDX    = STEP_W'(FETCH_STEPS - 1);

  state_e                 state_q, state_d;
  logic [STEP_W-1:0]      idx_q, idx_d;
  logic                   halt_pend_q, halt_pend_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic end_of_instr;

  // The last step always ends an instruction; finish only counts once the
  // sequence is past decode.
  assign end_of_instr = (idx_q == LAST_IDX) ||
                        (input_finish && (idx_q > DECODE_IDX));

  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_q     <= ST_RUN;
      idx_q       <= '0;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      halt_pend_q <= halt_pend_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic. Priority: clear > resume (HALTED) > end-of-instruction
  // > advance. done_d defaults to 0, so the pulse always self-clears even on
  // edges where the enable is low.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;
    done_d      = 1'b0;

    if (input_clock_enable) begin
      if (input_clear) begin
        state_d     = ST_RUN;
        idx_d       = '0;
        halt_pend_d = 1'b0;
      end else if (state_q == ST_HALTED) begin
        // A halt request while halted is dropped; only resume matters.
        if (input_resume) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end else if (end_of_instr) begin
        idx_d   = '0;
        done_d  = 1'b1;
        count_d = count_q + COUNT_WIDTH'(1);
        if (halt_pend_q || input_halt) begin
          state_d     = ST_HALTED;
          halt_pend_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + STEP_W'(1);
        if (input_halt) begin
          halt_pend_d = 1'b1;
        end
      end
    end
  end

  // Phase decode from registered index/state.
  logic run;
  assign run = (state_q == ST_RUN);

  always_comb begin
    output_step = '0;
    for (int i = 0; i < STEP_COUNT; i++) begin
      output_step[i] = run && (idx_q == STEP_W'(i));
    end
  end

  assign output_step_index  = run ? idx_q : '0;
  assign output_fetch       = run && (idx_q <  DECODE_IDX);
  assign output_decode      = run && (idx_q == DECODE_IDX);
  assign output_execute     = run && (idx_q >  DECODE_IDX);
  assign output_increment   = run && (idx_q == INC_IDX);
  assign output_halted      = (state_q == ST_HALTED);
  assign output_instr_done  = done_q;
  assign output_instr_count = count_q;

endmodule

// File: tb/tb_param_sequence_generator.sv
// -----------------------------------------------------------------------------
// Testbench for param_sequence_generator. Two instances share all stimulus:
// dut uses the defaults (6 steps, 2 fetch steps, 8-bit count) and dut_w2
// uses COUNT_WIDTH=2 so that the counter wrap is visible quickly.
// A table of {inputs, expected outputs} records is applied one edge per
// record, followed by hand-written sequences for the asynchronous reset with
// a pending halt and for the count wrap.
// -----------------------------------------------------------------------------
module tb_param_sequence_generator;

  localparam int STEP_COUNT  = 6;
  localparam int FETCH_STEPS = 2;
  localparam int STEP_W      = $clog2(STEP_COUNT);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic input_reset_n      = 1'b0;
  logic input_clock_enable = 1'b0;
  logic input_clear        = 1'b0;
  logic input_finish       = 1'b0;
  logic input_halt         = 1'b0;
  logic input_resume       = 1'b0;

  logic [STEP_COUNT-1:0] step_a, step_b;
  logic [STEP_W-1:0]     sidx_a, sidx_b;
  logic fetch_a, decode_a, exec_a, inc_a, halted_a, done_a;
  logic fetch_b, decode_b, exec_b, inc_b, halted_b, done_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  param_sequence_generator #(
    .STEP_COUNT(STEP_COUNT), .FETCH_STEPS(FETCH_STEPS), .COUNT_WIDTH(8)
  ) dut (
    .clock(clock), .input_reset_n(input_reset_n),
    .input_clock_enable(input_clock_enable), .input_clear(input_clear),
    .input_finish(input_finish), .input_halt(input_halt),
    .input_resume(input_resume),
    .output_step(step_a), .output_step_index(sidx_a),
    .output_fetch(fetch_a), .output_decode(decode_a),
    .output_execute(exec_a), .output_increment(inc_a),
    .output_halted(halted_a), .output_instr_done(done_a),
    .output_instr_count(count_a)
  );

  param_sequence_generator #(
    .STEP_COUNT(STEP_COUNT), .FETCH_STEPS(FETCH_STEPS), .COUNT_WIDTH(2)
  ) dut_w2 (
    .clock(clock), .input_reset_n(input_reset_n),
    .input_clock_enable(input_clock_enable), .input_clear(input_clear),
    .input_finish(input_finish), .input_halt(input_halt),
    .input_resume(input_resume),
    .output_step(step_b), .output_step_index(sidx_b),
    .output_fetch(fetch_b), .output_decode(decode_b),
    .output_execute(exec_b), .output_increment(inc_b),
    .output_halted(halted_b), .output_instr_done(done_b),
    .output_instr_count(count_b)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic ce, clr, fin, hlt, res;
    int   exp_idx;
    logic exp_halted;
    logic exp_done;
    int   exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ce, logic clr, logic fin, logic hlt,
                              logic res, int idx, logic halted, logic done,
                              int cnt);
    vec_t v;
    v.ce = ce; v.clr = clr; v.fin = fin; v.hlt = hlt; v.res = res;
    v.exp_idx = idx; v.exp_halted = halted; v.exp_done = done;
    v.exp_count = cnt;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  // Expected strobes come straight from the step-definition: fetch below
  // FETCH_STEPS, decode at FETCH_STEPS, execute above, increment at
  // FETCH_STEPS-1, everything dark while halted.
  task automatic check_all(input int n, input int idx, input logic halted,
                           input logic done, input int cnt);
    logic [31:0] e_step;
    logic e_fetch, e_dec, e_exec, e_inc;
    e_step = halted ? 32'd0 : (32'd1 << idx);
    e_fetch = !halted && (idx <  FETCH_STEPS);
    e_dec   = !halted && (idx == FETCH_STEPS);
    e_exec  = !halted && (idx >  FETCH_STEPS);
    e_inc   = !halted && (idx == FETCH_STEPS - 1);
    cmp("step",      n, 32'(step_a),   e_step);
    cmp("index",     n, 32'(sidx_a),   halted ? 32'd0 : 32'(idx));
    cmp("fetch",     n, 32'(fetch_a),  32'(e_fetch));
    cmp("decode",    n, 32'(decode_a), 32'(e_dec));
    cmp("execute",   n, 32'(exec_a),   32'(e_exec));
    cmp("increment", n, 32'(inc_a),    32'(e_inc));
    cmp("halted",    n, 32'(halted_a), 32'(halted));
    cmp("done",      n, 32'(done_a),   32'(done));
    cmp("count",     n, 32'(count_a),  32'(cnt % 256));
    cmp("w2_index",  n, 32'(sidx_b),   halted ? 32'd0 : 32'(idx));
    cmp("w2_done",   n, 32'(done_b),   32'(done));
    cmp("w2_count",  n, 32'(count_b),  32'(cnt % 4));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ce, input logic clr, input logic fin,
                       input logic hlt, input logic res);
    input_clock_enable = ce;
    input_clear        = clr;
    input_finish       = fin;
    input_halt         = hlt;
    input_resume       = res;
  endtask

  // One edge: inputs are already stable, sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int c8;

    // Advance through 12 edges: two full instructions.
    add(1,0,0,0,0, 1,0,0,0); add(1,0,0,0,0, 2,0,0,0); add(1,0,0,0,0, 3,0,0,0);
    add(1,0,0,0,0, 4,0,0,0); add(1,0,0,0,0, 5,0,0,0); add(1,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0, 1,0,0,1); add(1,0,0,0,0, 2,0,0,1); add(1,0,0,0,0, 3,0,0,1);
    add(1,0,0,0,0, 4,0,0,1); add(1,0,0,0,0, 5,0,0,1); add(1,0,0,0,0, 0,0,1,2);
    // Early finish at execute index 3; ignored at fetch index 1 and decode 2.
    add(1,0,0,0,0, 1,0,0,2); add(1,0,0,0,0, 2,0,0,2); add(1,0,0,0,0, 3,0,0,2);
    add(1,0,1,0,0, 0,0,1,3); add(1,0,0,0,0, 1,0,0,3); add(1,0,1,0,0, 2,0,0,3);
    add(1,0,1,0,0, 3,0,0,3); add(1,0,0,0,0, 4,0,0,3); add(1,0,0,0,0, 5,0,0,3);
    add(1,0,0,0,0, 0,0,1,4);
    // Halt for one edge at index 2, taken at the boundary; idle; resume.
    add(1,0,0,0,0, 1,0,0,4); add(1,0,0,0,0, 2,0,0,4); add(1,0,0,1,0, 3,0,0,4);
    add(1,0,0,0,0, 4,0,0,4); add(1,0,0,0,0, 5,0,0,4); add(1,0,0,0,0, 0,1,1,5);
    add(1,0,0,0,0, 0,1,0,5); add(1,0,0,1,0, 0,1,0,5); add(1,0,1,0,0, 0,1,0,5);
    add(1,0,0,0,0, 0,1,0,5); add(1,0,0,0,0, 0,1,0,5); add(1,0,0,0,1, 0,0,0,5);
    add(1,0,0,0,0, 1,0,0,5);
    // Enable low at index 4 with halt asserted: nothing latched.
    add(1,0,0,0,0, 2,0,0,5); add(1,0,0,0,0, 3,0,0,5); add(1,0,0,0,0, 4,0,0,5);
    add(0,0,0,1,0, 4,0,0,5); add(0,0,0,1,0, 4,0,0,5); add(0,0,0,1,0, 4,0,0,5);
    add(0,0,0,1,0, 4,0,0,5); add(1,0,0,0,0, 5,0,0,5); add(1,0,0,0,0, 0,0,1,6);
    // done drops on the next edge even with the enable low.
    add(0,0,0,0,0, 0,0,0,6); add(1,0,0,0,0, 1,0,0,6);
    // Clear at index 4 with a halt pending: no pulse, no count, no halt.
    add(1,0,0,0,0, 2,0,0,6); add(1,0,0,1,0, 3,0,0,6); add(1,0,0,0,0, 4,0,0,6);
    add(1,1,0,0,0, 0,0,0,6); add(1,0,0,0,0, 1,0,0,6); add(1,0,0,0,0, 2,0,0,6);
    add(1,0,0,0,0, 3,0,0,6); add(1,0,0,0,0, 4,0,0,6); add(1,0,0,0,0, 5,0,0,6);
    add(1,0,0,0,0, 0,0,1,7);
    // Halt on the last step halts at once; resume beats a simultaneous halt.
    add(1,0,0,0,0, 1,0,0,7); add(1,0,0,0,0, 2,0,0,7); add(1,0,0,0,0, 3,0,0,7);
    add(1,0,0,0,0, 4,0,0,7); add(1,0,0,0,0, 5,0,0,7); add(1,0,0,1,0, 0,1,1,8);
    add(1,0,0,1,1, 0,0,0,8); add(1,0,0,0,0, 1,0,0,8); add(1,0,0,0,0, 2,0,0,8);
    add(1,0,0,0,0, 3,0,0,8); add(1,0,0,0,0, 4,0,0,8);
    // finish+halt in execute halts; clear leaves HALTED.
    add(1,0,1,1,0, 0,1,1,9); add(1,1,0,0,0, 0,0,0,9); add(1,0,0,0,0, 1,0,0,9);

    // Reset, released away from the clock edge.
    drive(0,0,0,0,0);
    input_reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    input_reset_n = 1'b1;
    #1;
    check_all(-1, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ce, vecs[i].clr, vecs[i].fin, vecs[i].hlt, vecs[i].res);
      tick();
      check_all(i, vecs[i].exp_idx, vecs[i].exp_halted, vecs[i].exp_done,
                vecs[i].exp_count);
    end

    // Asynchronous reset mid-step with a halt pending (index 1 -> 2).
    n = 1000;
    drive(1,0,0,1,0);
    tick();
    check_all(n, 2, 1'b0, 1'b0, 9);
    drive(1,0,0,0,0);
    #2;
    input_reset_n = 1'b0;
    #1;
    check_all(n + 1, 0, 1'b0, 1'b0, 0);
    tick();
    check_all(n + 2, 0, 1'b0, 1'b0, 0);
    #2;
    input_reset_n = 1'b1;

    // The pending halt was lost: the first boundary keeps running. Then four
    // more instructions show the 2-bit count wrapping: 1,2,3,0,1.
    c8 = 0;
    for (int k = 0; k < 5; k++) begin
      for (int s = 1; s < STEP_COUNT; s++) begin
        tick();
        check_all(n + 10 + k * 10 + s, s, 1'b0, 1'b0, c8);
      end
      tick();
      c8++;
      check_all(n + 10 + k * 10, 0, 1'b0, 1'b1, c8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sequence_generator.md
Name: param_sequence_generator

Overview:
Parametrised successor to the CPU control-step ring counter in the decoder.
- Generates a one-hot control-step sequence with configurable length and fetch-phase width.
- Adds early instruction termination, halt/resume on instruction boundaries, and a completed-instruction counter.
- Sits between the clock/control logic and the instruction decoder, and drives the fetch/decode/execute/increment phase strobes.

Parameters:
STEP_COUNT, 6, number of control steps per full instruction (>= FETCH_STEPS+2)
FETCH_STEPS, 2, number of leading fetch steps (>= 1)
COUNT_WIDTH, 8, width of completed-instruction counter
(local) STEP_W = $clog2(STEP_COUNT)

Ports:
clock  input  1  system clock, rising edge
input_reset_n  input  1  asynchronous, active-low reset
input_clock_enable  input  1  advance enable; 0 holds all state
input_clear  input  1  synchronous restart to step 0
input_finish  input  1  early end of instruction (honoured in execute steps only)
input_halt  input  1  halt request, taken at next instruction boundary
input_resume  input  1  leave HALTED
output_step  output  STEP_COUNT  one-hot current step; all zero when halted
output_step_index  output  STEP_W  binary current step
output_fetch  output  1  index < FETCH_STEPS
output_decode  output  1  index == FETCH_STEPS
output_execute  output  1  index > FETCH_STEPS
output_increment  output  1  index == FETCH_STEPS-1 (PC increment step)
output_halted  output  1  in HALTED state
output_instr_done  output  1  one-cycle pulse after an instruction completes
output_instr_count  output  COUNT_WIDTH  completed instructions, wraps

Behaviour:
- Reset (input_reset_n=0, asynchronous): state RUN, index 0, halt_pending 0, instr_done 0, count 0.
  - Resulting outputs: output_step=...0001, fetch=1, increment=1 when FETCH_STEPS=1, else 0; all other strobes 0.
- States: RUN and HALTED. Phase outputs are combinational from the registered index/state.
  - In HALTED, step/fetch/decode/execute/increment are all 0 and index reads 0.
- Registered updates happen only on clock edges with input_clock_enable=1, except instr_done (below).
  - Priority per edge: reset > clear > resume (HALTED) > end-of-instruction > advance.
- clear: forces RUN, index 0 and halt_pending 0. Does not pulse done and does not count. Applies from HALTED too.
- RUN, end-of-instruction occurs when either:
  - index == STEP_COUNT-1, or
  - input_finish=1 while index > FETCH_STEPS.
  - input_finish during fetch/decode steps is ignored.
- At end-of-instruction:
  - index -> 0, instr_done <= 1, count <= count+1 (mod 2^COUNT_WIDTH).
  - If halt_pending or input_halt is 1 this edge: enter HALTED and clear halt_pending.
- RUN, otherwise: index -> index+1. If input_halt=1, halt_pending <= 1; it stays set until the boundary.
- HALTED:
  - input_resume=1 -> RUN at index 0. Resume wins over a simultaneous input_halt, which is dropped.
  - input_halt is ignored. Count is frozen.
- instr_done is high exactly one clock after the completing edge. It clears on the next rising edge regardless of input_clock_enable.
- input_clock_enable=0: index, state, halt_pending and count hold. input_halt is not sampled.
- Reset mid-instruction: immediate return to the reset values, and pending halt is lost.
- Count wraps from 2^COUNT_WIDTH-1 to 0 with no flag.

Test Plan:
1. Defaults, reset release, CE=1 for 12 edges → index 0,1,2,3,4,5,0,1,… ; fetch at 0–1, increment at 1, decode at 2, execute at 3–5; done pulses after edges 6 and 12; count=2.
2. finish=1 at index 3 → next index 0, done pulse, count+1. finish=1 at index 1 → ignored, index 2.
3. halt=1 for one edge at index 2 → continues 3,4,5, then HALTED: halted=1, step=0. Count is frozen across 5 idle edges. resume=1 → index 0 and fetch=1 next cycle.
4. CE=0 for 4 edges at index 4 → index stays 4. halt asserted meanwhile → not latched; reaching the boundary later does not halt.
5. clear=1 at index 4 with halt_pending set → index 0, no done pulse, count unchanged, pending cancelled (no halt at next boundary).
6. COUNT_WIDTH=2, run 5 full instructions → count sequence 1,2,3,0,1. Assert input_reset_n=0 asynchronously mid-step → all outputs return to reset values before the next clock edge.
